// File: rtl/i2c_rom_seq_engine_pkg.sv
// Shared types for the ROM-driven I2C/SCCB sequencer: command word, ROM opcodes,
// entry field positions and sequencer states.
package package_i2c;

  typedef struct packed {
    logic       we;
    logic       sccb_mode;
    logic [6:0] addr_slave;
    logic [7:0] addr_reg;
    logic [7:0] burst_num;
  } t_i2c_cmd;

  typedef enum logic [2:0] {
    RomOpWrite  = 3'b000,
    RomOpRdchk  = 3'b001,
    RomOpDelay  = 3'b010,
    RomOpSetslv = 3'b011,
    RomOpEnd    = 3'b111
  } t_rom_op;

  localparam logic [2:0] OpCodeEnd     = 3'b111;
  // Any opcode with the top bit set, other than END, is illegal.
  localparam logic [2:0] OpIllegalMask = 3'b100;

  localparam int unsigned OpMsb    = 23;
  localparam int unsigned OpLsb    = 21;
  localparam int unsigned RegMsb   = 15;
  localparam int unsigned RegLsb   = 8;
  localparam int unsigned DataMsb  = 7;
  localparam int unsigned CountMsb = 15;
  localparam int unsigned SlaveMsb = 6;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StCmdReq,
    StCmdWait,
    StDelay,
    StRetry
  } t_seq_state;

endpackage

// File: rtl/i2c_rom_seq_engine.sv
// Walks an external ROM of 24-bit entries and turns them into I2C/SCCB register
// writes, read-checks, delays and slave-address changes.
module i2c_rom_seq_engine
  import package_i2c::*;
#(
  parameter bit          p_sccb_mode      = 1'b1,
  parameter logic [6:0]  p_slave_addr     = 7'h21,
  parameter int unsigned p_rom_addr_width = 8,
  parameter int unsigned p_rom_latency    = 1,
  parameter int unsigned p_delay_unit     = 1024,
  parameter int unsigned p_max_retries    = 3,
  parameter bit          p_auto_init      = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  output logic [p_rom_addr_width-1:0] o_rom_addr,
  input  logic [23:0]                 i_rom_data,
  output logic                        o_cmd_valid,
  input  logic                        i_cmd_ready,
  output t_i2c_cmd                    o_cmd_data,
  output logic [7:0]                  o_wr_data,
  input  logic                        i_cmd_done,
  input  logic                        i_nack,
  input  logic [7:0]                  i_rd_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [p_rom_addr_width-1:0] o_err_addr
);

  typedef struct packed {
    t_seq_state                  state;
    logic [p_rom_addr_width-1:0] rom_addr;
    logic [1:0]                  lat_cnt;
    logic                        is_write;
    logic [7:0]                  reg_addr;
    logic [7:0]                  data;
    logic [6:0]                  slave;
    logic [31:0]                 timer;
    logic [7:0]                  retries;
    logic                        init_done;
    logic                        error;
    logic                        done;
    logic [p_rom_addr_width-1:0] err_addr;
  } t_regs;

  localparam t_regs RegsReset = '{
    state:     StIdle,
    rom_addr:  '0,
    lat_cnt:   '0,
    is_write:  1'b0,
    reg_addr:  '0,
    data:      '0,
    slave:     p_slave_addr,
    timer:     '0,
    retries:   '0,
    init_done: 1'b0,
    error:     1'b0,
    done:      1'b0,
    err_addr:  '0
  };

  localparam logic [1:0] LatLast = 2'(p_rom_latency - 1);

  t_regs       st_q, st_d;
  logic [2:0]  op;
  logic        decode_now;
  logic        unused_rom_bits;

  assign op              = i_rom_data[OpMsb:OpLsb];
  assign unused_rom_bits = ^i_rom_data[20:16];

  always_comb begin
    st_d         = st_q;
    st_d.done    = 1'b0;
    st_d.lat_cnt = '0;
    decode_now   = 1'b0;

    unique case (st_q.state)
      StIdle: begin
        if (i_start || (p_auto_init && !st_q.init_done)) begin
          st_d.init_done = 1'b1;
          st_d.rom_addr  = '0;
          st_d.error     = 1'b0;
          st_d.state     = StFetch;
        end
      end
      StFetch: begin
        // A zero-latency ROM is decoded in the same cycle the address is presented.
        if (p_rom_latency == 0) begin
          decode_now = 1'b1;
        end else if (st_q.lat_cnt == LatLast) begin
          st_d.state = StDecode;
        end else begin
          st_d.lat_cnt = st_q.lat_cnt + 2'd1;
        end
      end
      StDecode: decode_now = 1'b1;
      StCmdReq: begin
        if (i_cmd_ready) st_d.state = StCmdWait;
      end
      StCmdWait: begin
        if (i_cmd_done) begin
          if (i_nack) begin
            if (st_q.retries < 8'(p_max_retries)) begin
              st_d.retries = st_q.retries + 8'd1;
              st_d.state   = StRetry;
            end else begin
              st_d.error    = 1'b1;
              st_d.err_addr = st_q.rom_addr;
              st_d.done     = 1'b1;
              st_d.state    = StIdle;
            end
          end else begin
            if (!st_q.is_write && (i_rd_data != st_q.data)) begin
              st_d.error    = 1'b1;
              st_d.err_addr = st_q.rom_addr;
            end
            st_d.rom_addr = st_q.rom_addr + 1'b1;
            st_d.state    = StFetch;
          end
        end
      end
      StDelay: begin
        if (st_q.timer == 32'd0) st_d.state = StFetch;
        else                     st_d.timer = st_q.timer - 32'd1;
      end
      StRetry: st_d.state = StCmdReq;
      default: st_d = RegsReset;
    endcase

    if (decode_now) begin
      if (op == OpCodeEnd) begin
        st_d.done  = 1'b1;
        st_d.state = StIdle;
      end else if ((op & OpIllegalMask) != 3'b000) begin
        st_d.error    = 1'b1;
        st_d.err_addr = st_q.rom_addr;
        st_d.done     = 1'b1;
        st_d.state    = StIdle;
      end else begin
        case (op)
          RomOpWrite, RomOpRdchk: begin
            st_d.is_write = (op == RomOpWrite);
            st_d.reg_addr = i_rom_data[RegMsb:RegLsb];
            st_d.data     = i_rom_data[DataMsb:0];
            st_d.retries  = '0;
            st_d.state    = StCmdReq;
          end
          RomOpSetslv: begin
            st_d.slave    = i_rom_data[SlaveMsb:0];
            st_d.rom_addr = st_q.rom_addr + 1'b1;
            st_d.state    = StFetch;
          end
          RomOpDelay: begin
            st_d.rom_addr = st_q.rom_addr + 1'b1;
            if (i_rom_data[CountMsb:0] == 16'd0) begin
              st_d.state = StFetch;
            end else begin
              st_d.timer = 32'(i_rom_data[CountMsb:0]) * 32'(p_delay_unit) - 32'd1;
              st_d.state = StDelay;
            end
          end
          default: st_d.state = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) st_q <= RegsReset;
    else       st_q <= st_d;
  end

  assign o_rom_addr            = st_q.rom_addr;
  assign o_cmd_valid           = (st_q.state == StCmdReq);
  assign o_cmd_data.we         = st_q.is_write;
  assign o_cmd_data.sccb_mode  = p_sccb_mode;
  assign o_cmd_data.addr_slave = st_q.slave;
  assign o_cmd_data.addr_reg   = st_q.reg_addr;
  assign o_cmd_data.burst_num  = 8'd0;
  assign o_wr_data             = st_q.data;
  assign o_busy                = (st_q.state != StIdle);
  assign o_done                = st_q.done;
  assign o_error               = st_q.error;
  assign o_err_addr            = st_q.err_addr;

endmodule

// File: tb/tb_i2c_rom_seq_engine.sv
// Self-checking bench: ROM model, I2C responder, directed scenarios and random
// programs checked against a behavioural sequence model.
module tb_i2c_rom_seq_engine;
  import package_i2c::*;

  localparam int DU = 4;
  localparam int MR = 3;
  localparam logic [23:0] E_END = 24'hE00000;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] rom_addr, err_addr;
  logic [23:0] rom_data;
  logic       cmd_valid, cmd_ready = 1'b1;
  t_i2c_cmd   cmd_data;
  logic [7:0] wr_data;
  logic       cmd_done = 1'b0, nack = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       busy, done, error;

  always #5 clk = ~clk;

  i2c_rom_seq_engine #(.p_delay_unit(DU), .p_max_retries(MR)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_data(cmd_data), .o_wr_data(wr_data), .i_cmd_done(cmd_done), .i_nack(nack),
    .i_rd_data(rd_data), .o_busy(busy), .o_done(done), .o_error(error),
    .o_err_addr(err_addr)
  );

  logic [23:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic       we;
    logic [6:0] slv;
    logic [7:0] ra;
    logic [7:0] wd;
    logic       sccb;
    logic [7:0] burst;
  } xfer_t;

  xfer_t      got_q[$], exp_q[$];
  int         done_cnt = 0, total = 0, bad = 0;
  int         resp_delay = 5, nack_n = 0;
  logic [7:0] rd_val = 8'h00;
  logic [6:0] m_slave = 7'h21;
  bit         rand_ready = 1'b0;

  // Target-side responder: records transfers, answers each after resp_delay cycles.
  initial begin : responder
    int pend = 0, nack_run = 0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      nack     = 1'b0;
      if (done) done_cnt++;
      if (rst || start) begin pend = 0; nack_run = 0; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cmd_done = 1'b1;
          nack     = (nack_run < nack_n);
          rd_data  = rd_val;
          if (nack) nack_run++; else nack_run = 0;
        end
      end
      if (cmd_valid && cmd_ready && !rst) begin
        got_q.push_back('{we: cmd_data.we, slv: cmd_data.addr_slave, ra: cmd_data.addr_reg,
                          wd: wr_data, sccb: cmd_data.sccb_mode, burst: cmd_data.burst_num});
        pend = resp_delay;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] e_wr(input logic [7:0] r, input logic [7:0] d);
    return {3'b000, 5'b0, r, d};
  endfunction
  function automatic logic [23:0] e_rd(input logic [7:0] r, input logic [7:0] d);
    return {3'b001, 5'b0, r, d};
  endfunction
  function automatic logic [23:0] e_dly(input logic [15:0] c);
    return {3'b010, 5'b0, c};
  endfunction
  function automatic logic [23:0] e_slv(input logic [6:0] a);
    return {3'b011, 14'b0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) cmd_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic load4(input logic [23:0] a, b, c, d);
    for (int i = 0; i < 256; i++) rom[i] = E_END;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_slave = 7'h21;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (4) tick();
  endtask

  // Expected transfers and error outcome of one run, from the opcode rules.
  task automatic model_run(output bit e_err, output logic [7:0] e_eaddr);
    int a = 0;
    bit fin = 1'b0;
    exp_q.delete();
    e_err = 1'b0;
    e_eaddr = 8'h00;
    for (int step = 0; step < 300 && !fin; step++) begin
      logic [23:0] e;
      logic [2:0]  o;
      e = rom[a];
      o = e[23:21];
      if (o == 3'b000 || o == 3'b001) begin
        int att = 0;
        bit acked = 1'b0;
        while (!acked && att <= MR) begin
          exp_q.push_back('{we: (o == 3'b000), slv: m_slave, ra: e[15:8], wd: e[7:0],
                            sccb: 1'b1, burst: 8'h00});
          acked = (att >= nack_n);
          att++;
        end
        if (!acked) begin e_err = 1'b1; e_eaddr = 8'(a); fin = 1'b1; end
        else if (o == 3'b001 && rd_val != e[7:0]) begin e_err = 1'b1; e_eaddr = 8'(a); end
      end else if (o == 3'b011) begin
        m_slave = e[6:0];
      end else if (o == 3'b111) begin
        fin = 1'b1;
      end else if (o != 3'b010) begin
        e_err = 1'b1; e_eaddr = 8'(a); fin = 1'b1;
      end
      a = (a + 1) % 256;
    end
  endtask

  task automatic test_reset();
    int d0, n0;
    bit ok;
    load4(E_END, E_END, E_END, E_END);
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, cmd_valid, done, error, err_addr, rom_addr} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {busy, cmd_valid, done, error, err_addr, rom_addr});
    end
    d0 = done_cnt; n0 = got_q.size();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    wait_done(50, ok);
    total++;
    if (!ok || done_cnt - d0 != 1) begin
      bad++; $display("FAIL auto_init: done pulses=%0d want 1", done_cnt - d0);
    end
    total++;
    if (got_q.size() != n0) begin
      bad++; $display("FAIL auto_init_xfers: got %0d want 0", got_q.size() - n0);
    end
  endtask

  task automatic test_write();
    int d0, n0;
    bit ok;
    xfer_t x;
    load4(e_wr(8'h12, 8'h80), E_END, E_END, E_END);
    resp_delay = 5;
    d0 = done_cnt; n0 = got_q.size();
    pulse_start();
    wait_done(100, ok);
    x = got_q[n0];
    total++;
    if (!ok || got_q.size() - n0 != 1 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL write_count: xfers=%0d dones=%0d want 1/1",
                      got_q.size() - n0, done_cnt - d0);
    end
    total++;
    if ({x.we, x.ra, x.wd, x.slv, x.sccb, x.burst} !== {1'b1, 8'h12, 8'h80, 7'h21, 1'b1, 8'h0})
    begin
      bad++; $display("FAIL write_fields: got %h want 1/12/80/21/1/00", x);
    end
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL write_error: got %b want 0", error); end
  endtask

  task automatic test_setslv();
    int n0;
    bit ok;
    load4(e_slv(7'h30), e_wr(8'h44, 8'h55), E_END, E_END);
    n0 = got_q.size();
    pulse_start();
    wait_done(100, ok);
    total++;
    if (!ok || got_q[n0].slv !== 7'h30) begin
      bad++; $display("FAIL setslv_first: slave=%h want 30", got_q[n0].slv);
    end
    load4(e_wr(8'h66, 8'h77), E_END, E_END, E_END);
    n0 = got_q.size();
    pulse_start();
    wait_done(100, ok);
    total++;
    if (!ok || got_q[n0].slv !== 7'h30) begin
      bad++; $display("FAIL setslv_restart: slave=%h want 30", got_q[n0].slv);
    end
    n0 = got_q.size();
    do_reset();
    wait_done(100, ok);
    total++;
    if (!ok || got_q.size() - n0 != 1 || got_q[n0].slv !== 7'h21) begin
      bad++; $display("FAIL setslv_reset: slave=%h want 21", got_q[n0].slv);
    end
  endtask

  task automatic test_delay();
    int counts[2] = '{2, 0};
    foreach (counts[k]) begin
      int t1 = -1, t2 = -1, d0, n0;
      bit ok = 1'b0;
      load4(e_dly(16'(counts[k])), e_wr(8'h01, 8'h02), E_END, E_END);
      d0 = done_cnt; n0 = got_q.size();
      pulse_start();
      for (int c = 0; c < 300; c++) begin
        start = (t1 >= 0 && c == t1 + 3);
        tick();
        if (rom_addr == 8'd1 && t1 < 0) t1 = c;
        if (cmd_valid && t2 < 0) t2 = c;
        if (done_cnt != d0) begin ok = 1'b1; break; end
      end
      start = 1'b0;
      repeat (4) tick();
      total++;
      if (t1 < 0 || t2 - t1 != 2 + counts[k] * DU) begin
        bad++; $display("FAIL delay_%0d_cycles: got %0d want %0d", counts[k], t2 - t1,
                        2 + counts[k] * DU);
      end
      total++;
      if (!ok || got_q.size() - n0 != 1 || done_cnt - d0 != 1) begin
        bad++; $display("FAIL delay_%0d_run: xfers=%0d dones=%0d want 1/1", counts[k],
                        got_q.size() - n0, done_cnt - d0);
      end
    end
  endtask

  task automatic test_nack();
    int d0, n0;
    bit ok;
    load4(e_slv(7'h21), e_wr(8'h5A, 8'hA5), E_END, E_END);
    nack_n = 100;
    d0 = done_cnt; n0 = got_q.size();
    pulse_start();
    wait_done(300, ok);
    nack_n = 0;
    total++;
    if (!ok || got_q.size() - n0 != MR + 1) begin
      bad++; $display("FAIL nack_xfers: got %0d want %0d", got_q.size() - n0, MR + 1);
    end
    total++;
    if ({error, err_addr} !== {1'b1, 8'd1} || done_cnt - d0 != 1) begin
      bad++; $display("FAIL nack_status: err=%b addr=%0d dones=%0d want 1/1/1", error,
                      err_addr, done_cnt - d0);
    end
    load4(e_wr(8'h01, 8'h02), e_wr(8'h03, 8'h04), E_END, E_END);
    nack_n = 2;
    d0 = done_cnt; n0 = got_q.size();
    pulse_start();
    wait_done(300, ok);
    nack_n = 0;
    total++;
    if (!ok || got_q.size() - n0 != 6 || error !== 1'b0 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL retry_recover: xfers=%0d err=%b want 6/0", got_q.size() - n0,
                      error);
    end
  endtask

  task automatic test_rdchk();
    int d0, n0;
    bit ok;
    load4(e_rd(8'h10, 8'h5A), e_wr(8'h20, 8'h21), E_END, E_END);
    rd_val = 8'h5B;
    d0 = done_cnt; n0 = got_q.size();
    pulse_start();
    wait_done(200, ok);
    total++;
    if (!ok || got_q.size() - n0 != 2 || got_q[n0].we !== 1'b0 || got_q[n0].ra !== 8'h10) begin
      bad++; $display("FAIL rdchk_xfers: n=%0d we=%b reg=%h want 2/0/10", got_q.size() - n0,
                      got_q[n0].we, got_q[n0].ra);
    end
    total++;
    if ({error, err_addr} !== {1'b1, 8'd0} || done_cnt - d0 != 1) begin
      bad++; $display("FAIL rdchk_error: err=%b addr=%0d want 1/0", error, err_addr);
    end
    rd_val = 8'h5A;
    pulse_start();
    wait_done(200, ok);
    total++;
    if (!ok || error !== 1'b0) begin
      bad++; $display("FAIL rdchk_restart: err=%b want 0", error);
    end
  endtask

  task automatic test_illegal();
    int d0, n0;
    bit ok;
    load4(e_wr(8'h01, 8'h02), e_slv(7'h22), 24'hA00000, E_END);
    d0 = done_cnt; n0 = got_q.size();
    pulse_start();
    wait_done(200, ok);
    total++;
    if (!ok || {error, err_addr} !== {1'b1, 8'd2} || done_cnt - d0 != 1 ||
        got_q.size() - n0 != 1) begin
      bad++; $display("FAIL illegal: err=%b addr=%0d dones=%0d want 1/2/1", error, err_addr,
                      done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    int d0, n0;
    bit ok;
    t_i2c_cmd c0;
    logic [7:0] w0;
    load4(e_wr(8'h33, 8'h44), E_END, E_END, E_END);
    cmd_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 20 && !cmd_valid; c++) tick();
    c0 = cmd_data; w0 = wr_data;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (!cmd_valid || cmd_data !== c0 || wr_data !== w0) begin
        bad++; $display("FAIL stall_stable_%0d: v=%b cmd=%h wd=%h want 1/%h/%h", c, cmd_valid,
                        cmd_data, wr_data, c0, w0);
      end
    end
    d0 = done_cnt; n0 = got_q.size();
    rst = 1'b1;
    tick();
    total++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL stall_reset_drop: valid=%b busy=%b want 0/0", cmd_valid, busy);
    end
    tick();
    rst = 1'b0;
    repeat (10) tick();
    total++;
    if (done_cnt != d0 || got_q.size() != n0) begin
      bad++; $display("FAIL stall_reset_nodone: dones=%0d xfers=%0d want 0/0", done_cnt - d0,
                      got_q.size() - n0);
    end
    cmd_ready = 1'b1;
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_recover: done=0 want 1"); end
  endtask

  task automatic test_wrap();
    int d0, n0;
    bit ok = 1'b0, patched = 1'b0;
    rom[0] = e_wr(8'h01, 8'h02);
    for (int i = 1; i < 256; i++) rom[i] = e_slv(7'(i));
    d0 = done_cnt; n0 = got_q.size();
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!patched && got_q.size() > n0) begin rom[0] = E_END; patched = 1'b1; end
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (4) tick();
    total++;
    if (!ok || got_q.size() - n0 != 1 || error !== 1'b0 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL wrap: xfers=%0d err=%b dones=%0d want 1/0/1", got_q.size() - n0,
                      error, done_cnt - d0);
    end
    load4(e_wr(8'h09, 8'h09), E_END, E_END, E_END);
    n0 = got_q.size();
    pulse_start();
    wait_done(100, ok);
    total++;
    if (!ok || got_q[n0].slv !== 7'h7F) begin
      bad++; $display("FAIL wrap_slave: got %h want 7f", got_q[n0].slv);
    end
  endtask

  task automatic test_random();
    bit ok, e_err;
    logic [7:0] e_eaddr;
    load4(E_END, E_END, E_END, E_END);
    do_reset();
    wait_done(50, ok);
    for (int r = 0; r < 10; r++) begin
      int d0, n0, len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < 256; i++) rom[i] = E_END;
      for (int i = 0; i < len; i++) begin
        int k = $urandom_range(0, 19);
        logic [15:0] lo = 16'($urandom);
        if (k < 7)       rom[i] = {3'b000, 5'b0, lo};
        else if (k < 11) rom[i] = {3'b001, 5'b0, lo};
        else if (k < 14) rom[i] = e_dly(16'($urandom_range(0, 3)));
        else if (k < 18) rom[i] = e_slv(7'($urandom));
        else if (k < 19) rom[i] = {3'(4 + $urandom_range(0, 2)), 21'h0};
        else             rom[i] = {3'b001, 5'b0, lo[15:8], rd_val};
      end
      nack_n = $urandom_range(0, 4);
      rd_val = 8'($urandom_range(0, 3));
      resp_delay = $urandom_range(1, 4);
      model_run(e_err, e_eaddr);
      rand_ready = 1'b1;
      d0 = done_cnt; n0 = got_q.size();
      pulse_start();
      wait_done(3000, ok);
      rand_ready = 1'b0;
      cmd_ready = 1'b1;
      total++;
      if (!ok || done_cnt - d0 != 1 || got_q.size() - n0 != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count: xfers=%0d want %0d dones=%0d", r,
                        got_q.size() - n0, exp_q.size(), done_cnt - d0);
      end
      for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
        xfer_t g = got_q[n0 + i];
        xfer_t e = exp_q[i];
        total++;
        if ({g.we, g.slv, g.ra, g.sccb, g.burst} !== {e.we, e.slv, e.ra, e.sccb, e.burst} ||
            (e.we && g.wd !== e.wd)) begin
          bad++; $display("FAIL rand%0d_xfer%0d: got %h want %h", r, i, g, e);
        end
      end
      total++;
      if (error !== e_err || (e_err && err_addr !== e_eaddr)) begin
        bad++; $display("FAIL rand%0d_error: err=%b addr=%0d want %b/%0d", r, error, err_addr,
                        e_err, e_eaddr);
      end
    end
    nack_n = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_setslv();
    test_delay();
    test_nack();
    test_rdchk();
    test_illegal();
    test_stall();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_rom_seq_engine.md
I2C_ROM_SEQ_ENGINE -- requirements
Module: i2c_rom_seq_engine

Interface
- REQ-001 SHALL have parameter p_sccb_mode, default 1, setting the sccb_mode field of every issued command.
- REQ-002 SHALL have parameter p_slave_addr, default 'h21, the initial 7-bit slave address.
- REQ-003 SHALL have parameter p_rom_addr_width, default 8, the ROM address width.
- REQ-004 SHALL have parameter p_rom_latency, default 1, the ROM read latency in cycles, range 0..3.
- REQ-005 SHALL have parameter p_delay_unit, default 1024, the number of clocks per DELAY count.
- REQ-006 SHALL have parameter p_max_retries, default 3, the number of NACK retries per entry.
- REQ-007 SHALL have parameter p_auto_init, default 1, which starts one sequence after reset without i_start.
- REQ-008 i_clk  in  1  clock; all logic on the rising edge.
- REQ-009 i_rst  in  1  reset, synchronous, active-high.
- REQ-010 i_start  in  1  start-sequence pulse; ignored unless IDLE.
- REQ-011 o_rom_addr  out  p_rom_addr_width  ROM address.
- REQ-012 i_rom_data  in  24  ROM entry.
- REQ-013 o_cmd_valid / i_cmd_ready  out/in  1  command valid/ready handshake.
- REQ-014 o_cmd_data  out  t_i2c_cmd  command: we, sccb_mode, addr_slave, addr_reg, burst_num=0.
- REQ-015 o_wr_data  out  8  write byte.
- REQ-016 i_cmd_done / i_nack / i_rd_data  in  1/1/8  transaction-complete pulse, NACK flag and read byte, all qualified by i_cmd_done.
- REQ-017 o_busy / o_done / o_error / o_err_addr  out  1/1/1/p_rom_addr_width  status outputs.

Function
- REQ-018 SHALL decode the opcode from entry bits [23:21] as follows.
  - 000 WRITE: reg [15:8], data [7:0].
  - 001 RDCHK: reg [15:8], expected value [7:0].
  - 010 DELAY: wait [15:0]*p_delay_unit clocks.
  - 011 SETSLV: new slave address in [6:0].
  - 111 END.
  - Any other opcode is ILLEGAL.
- REQ-019 SHALL use the states IDLE, FETCH, DECODE, CMD_REQ, CMD_WAIT, DELAY and RETRY.
- REQ-020 IDLE: on i_start, or on first entry after reset when p_auto_init=1, SHALL set rom_addr=0, clear o_error and go to FETCH.
- REQ-021 FETCH SHALL last exactly p_rom_latency cycles; when p_rom_latency=0, DECODE SHALL follow in the same cycle.
- REQ-022 DECODE for WRITE and RDCHK SHALL latch the entry and go to CMD_REQ, with we=1 for WRITE and we=0 for RDCHK.
- REQ-023 DECODE for SETSLV SHALL update the slave register, increment the address and go to FETCH, taking 1 cycle.
- REQ-024 DECODE for DELAY SHALL load the timer with count*p_delay_unit-1 and increment the address; a zero count SHALL return directly to FETCH.
- REQ-025 DECODE for END SHALL pulse o_done for 1 cycle and go to IDLE.
- REQ-026 DECODE for ILLEGAL SHALL set o_error, load o_err_addr with the current address, pulse o_done and go to IDLE.
- REQ-027 CMD_REQ SHALL hold o_cmd_valid high with stable o_cmd_data and o_wr_data until i_cmd_ready; transfer occurs on valid&&ready, then the block SHALL go to CMD_WAIT.
- REQ-028 CMD_WAIT on i_cmd_done without i_nack SHALL complete the entry, as follows.
  - WRITE: increment the address and go to FETCH.
  - RDCHK with i_rd_data != expected: set o_error and o_err_addr; the sequence SHALL continue.
- REQ-029 CMD_WAIT on i_cmd_done with i_nack SHALL act on the retry count.
  - If retries < p_max_retries: increment the count and go to RETRY for 1 cycle, then CMD_REQ.
  - Otherwise: set o_error and o_err_addr, pulse o_done and go to IDLE.
  - The retry count SHALL clear on each new entry.
- REQ-030 The DELAY timer SHALL decrement each cycle, and the block SHALL go to FETCH the cycle after the timer reads 0.
- REQ-031 The ROM address SHALL wrap at 2**p_rom_addr_width-1 to 0 without error.
- REQ-032 i_start while not IDLE SHALL be ignored; i_cmd_done outside CMD_WAIT SHALL be ignored.
- REQ-033 o_busy SHALL be high in every state except IDLE.
- REQ-034 An unreachable state SHALL recover to the reset values.

Reset
- REQ-035 Reset SHALL force the following values:
  - state IDLE, all outputs 0 (o_cmd_valid, o_done, o_error, o_busy, o_err_addr, o_rom_addr);
  - slave register = p_slave_addr;
  - init flag 0.
- REQ-036 Reset asserted mid-transaction SHALL abort at once, drop o_cmd_valid on the next cycle and emit no o_done pulse.

Structure
- REQ-037 The package_i2c package SHALL hold the t_i2c_cmd typedef, the opcode enum t_rom_op and the END, ILLEGAL and field-position constants.
- REQ-038 The design SHALL use a single module built around a registered state struct with next-state logic; it SHALL contain no sub-modules, and the ROM SHALL be external.

Verification
- REQ-039 WRITE 0x12/0x80 then END, with ready=1 and done 5 cycles later: exactly one transfer with we=1, addr_reg 0x12, wr_data 0x80, addr_slave 0x21; then one o_done pulse.
- REQ-040 SETSLV 0x30, then WRITE, then END: the command carries addr_slave 0x30; after a restart it carries 0x30 again, and after reset it carries 0x21.
- REQ-041 DELAY count 2 with p_delay_unit=4: exactly 8 cycles pass between the DELAY DECODE and the next FETCH.
- REQ-042 NACK on every attempt with p_max_retries=3: exactly 4 transfers, then o_error=1, o_err_addr equals the entry address and one o_done pulse.
- REQ-043 RDCHK expecting 0x5A while i_rd_data=0x5B: we=0, o_error=1, the sequence continues to END with o_done=1; a restart clears o_error.
- REQ-044 i_cmd_ready held low for 10 cycles: o_cmd_valid and o_cmd_data stay stable throughout; reset asserted mid-wait returns the block to IDLE with no o_done pulse.
